// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] LOADUSE_STALL = 2'd1;
  localparam logic [1:0] BR_ALU_STALL  = 2'd1;
  localparam logic [1:0] BR_LOAD_STALL = 2'd2;
  localparam logic [4:0] REG_ZERO      = 5'd0;

  // True when the EX destination feeds a source the ID instruction actually reads.
  function automatic logic src_match(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for hazard performance events.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count enabled events, sticking at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / branch-in-ID stalls, control flushes and
// dmem-busy holds for the IF/ID, ID/EX registers and the PC.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_dst,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hold_cycles,
  output logic [CNT_W-1:0] flush_events
);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_eff_state;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_len;
  logic       w_match;
  logic       w_do_stall;
  logic       w_do_hold;
  logic       w_inc_stall;
  logic       w_inc_hold;
  logic       w_inc_flush;

  assign w_match = src_match(ex_dst, id_rs, id_rt, id_uses_rt);

  // Stall length of the hazard seen this cycle; branch-after-load needs the longest wait.
  always_comb begin
    w_len = 2'd0;
    if (id_branch && ex_memread && w_match) begin
      w_len = BR_LOAD_STALL;
    end else if (ex_memread && w_match) begin
      w_len = LOADUSE_STALL;
    end else if (id_branch && ex_regwrite && w_match) begin
      w_len = BR_ALU_STALL;
    end else begin
      w_len = 2'd0;
    end
  end

  // The release cycle of a hold behaves as the state being resumed.
  always_comb begin
    w_eff_state = r_state;
    if ((r_state == HOLD) && !dmem_busy) begin
      w_eff_state = (r_cnt != 2'd0) ? STALL : RUN;
    end else begin
      w_eff_state = r_state;
    end
  end

  // Next-state and stall bookkeeping.
  always_comb begin
    w_do_hold   = 1'b0;
    w_do_stall  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (w_eff_state)
      RUN: begin
        if (dmem_busy) begin
          w_do_hold   = 1'b1;
          w_state_nxt = HOLD;
        end else if (w_len != 2'd0) begin
          w_do_stall  = 1'b1;
          w_cnt_nxt   = w_len - 2'd1;
          w_state_nxt = (w_len == 2'd1) ? RUN : STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      STALL: begin
        if (dmem_busy) begin
          w_do_hold   = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_cnt <= 2'd1) begin
          w_do_stall  = 1'b1;
          w_cnt_nxt   = 2'd0;
          w_state_nxt = RUN;
        end else begin
          w_do_stall  = 1'b1;
          w_cnt_nxt   = r_cnt - 2'd1;
          w_state_nxt = STALL;
        end
      end
      HOLD: begin
        w_do_hold   = 1'b1;
        w_state_nxt = HOLD;
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Pipeline control outputs; priority is reset, hold, stall, then normal flow.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (!reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_hold  = 1'b0;
    end else if (w_do_hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (w_do_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      ifid_flush = id_jump || (id_branch && id_branch_taken);
    end
  end

  // FSM state and remaining-stall register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_inc_stall = reset && w_do_stall;
  assign w_inc_hold  = reset && w_do_hold;
  assign w_inc_flush = reset && ifid_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock), .reset (reset), .inc (w_inc_stall), .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clock (clock), .reset (reset), .inc (w_inc_hold), .count (hold_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock), .reset (reset), .inc (w_inc_flush), .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_dst;
  logic             id_uses_rt, id_branch, id_branch_taken, id_jump;
  logic             ex_memread, ex_regwrite, dmem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
  logic [CNT_W-1:0] stall_cycles, hold_cycles, flush_events;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  localparam logic [4:0] O_RESET  = 5'b00110;
  localparam logic [4:0] O_NORMAL = 5'b11000;
  localparam logic [4:0] O_FLUSH  = 5'b11100;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_HOLD   = 5'b00001;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clock (clock), .reset (reset),
    .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
    .id_branch (id_branch), .id_branch_taken (id_branch_taken), .id_jump (id_jump),
    .ex_memread (ex_memread), .ex_regwrite (ex_regwrite), .ex_dst (ex_dst),
    .dmem_busy (dmem_busy),
    .pc_write (pc_write), .ifid_write (ifid_write), .ifid_flush (ifid_flush),
    .idex_flush (idex_flush), .pipe_hold (pipe_hold),
    .stall_cycles (stall_cycles), .hold_cycles (hold_cycles), .flush_events (flush_events)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    #1;
    check_eq(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold},
             {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    id_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst = 5'd0; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_in();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic ex_lw(input logic [4:0] dst);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = dst;
  endtask

  task automatic ex_bubble();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst = 5'd0;
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    #2;
    check_eq("rst_outs", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold},
             {27'd0, O_RESET});
    check_eq("rst_cnts", {stall_cycles, hold_cycles | flush_events}, 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Load-use: one stall cycle, then normal flow.
    ex_lw(5'd8); id_rs = 5'd8;
    chk_out("lu_stall", O_STALL);
    tick();
    ex_bubble();
    chk_out("lu_after", O_NORMAL);
    check_eq("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);

    // Branch after lw: two stalls without flush, then taken flush.
    do_reset();
    ex_lw(5'd9); id_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1; id_branch_taken = 1'b1;
    chk_out("bl_stall1", O_STALL);
    tick();
    ex_bubble();
    chk_out("bl_stall2", O_STALL);
    tick();
    chk_out("bl_taken", O_FLUSH);
    tick();
    clear_in();
    chk_out("bl_after", O_NORMAL);
    check_eq("bl_flush_cnt", {16'd0, flush_events}, 32'd1);
    check_eq("bl_stall_cnt", {16'd0, stall_cycles}, 32'd2);

    // Register zero never creates a hazard.
    ex_lw(5'd0); id_rs = 5'd0;
    chk_out("r0_nostall", O_NORMAL);
    tick();

    // Hold interleaved into a 2-cycle stall.
    do_reset();
    ex_lw(5'd9); id_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    chk_out("hs_stall1", O_STALL);
    tick();
    ex_bubble(); dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("hs_hold", O_HOLD);
      tick();
    end
    dmem_busy = 1'b0;
    chk_out("hs_stall2", O_STALL);
    tick();
    chk_out("hs_run", O_NORMAL);
    check_eq("hs_hold_cnt", {16'd0, hold_cycles}, 32'd3);
    check_eq("hs_stall_cnt", {16'd0, stall_cycles}, 32'd2);

    // Taken branch after ALU producer: stall only, flush on the next cycle.
    do_reset();
    ex_regwrite = 1'b1; ex_dst = 5'd3; id_branch = 1'b1; id_branch_taken = 1'b1; id_rs = 5'd3;
    chk_out("ba_stall", O_STALL);
    tick();
    ex_bubble();
    chk_out("ba_flush", O_FLUSH);
    tick();

    // Jump alongside a load-use hazard: stall wins over flush.
    clear_in();
    ex_lw(5'd8); id_rs = 5'd8; id_jump = 1'b1;
    chk_out("jl_stall", O_STALL);
    tick();
    ex_bubble();
    chk_out("jl_flush", O_FLUSH);
    tick();
    check_eq("jl_flush_cnt", {16'd0, flush_events}, 32'd2);

    // Busy in the detection cycle: hold first, then the hazard is re-detected.
    clear_in();
    ex_lw(5'd8); id_rs = 5'd8; dmem_busy = 1'b1;
    chk_out("bh_hold", O_HOLD);
    tick();
    dmem_busy = 1'b0;
    chk_out("bh_stall", O_STALL);
    tick();

    // Reset mid-STALL discards the remaining stall.
    do_reset();
    ex_lw(5'd9); id_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    chk_out("rs_stall1", O_STALL);
    tick();
    reset = 1'b0;
    ex_bubble();
    chk_out("rs_low", O_RESET);
    check_eq("rs_cnts", {stall_cycles, hold_cycles | flush_events}, 32'd0);
    tick();
    reset = 1'b1;
    chk_out("rs_run", O_NORMAL);
    tick();

    // Saturation of the stall counter under a continuous load-use hazard.
    do_reset();
    ex_lw(5'd8); id_rs = 5'd8;
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    check_eq("sat_pre", {16'd0, stall_cycles}, 32'h0000FFFE);
    tick();
    check_eq("sat_max", {16'd0, stall_cycles}, 32'h0000FFFF);
    tick();
    check_eq("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
    chk_out("sat_outs", O_STALL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
